cache_fill_ctrl: RTL and testbench

//   Access sequencer between the CPU and the 8-bit lookup cache (cell = {addr,data}).
//   - Serves read hits from the cache.
//   - On a read miss, fetches the byte from external memory with a req/ack handshake,

---
 rtl/bf8b_pkg.sv | 23 ++
 rtl/wait_timer.sv | 38 +++
 rtl/cache_fill_ctrl.sv | 144 ++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf8b_pkg.sv
// Shared types and constants for the cache fill sequencer.
package bf8b_pkg;

    // state      | meaning
    // ST_IDLE    | waiting for cpu_req
    // ST_LOOKUP  | registered cache lookup result arriving
    // ST_MEM_RD  | read miss, waiting on mem_ack
    // ST_MEM_WR  | write-through, waiting on mem_ack
    // ST_FILL    | one-cycle insert of {addr,data} into the cache
    // ST_RESP    | one-cycle completion pulse to the CPU
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_FILL   = 3'd4,
        ST_RESP   = 3'd5
    } fill_state_t;

    localparam int         MEM_TIMEOUT_DEFAULT = 255;
    localparam logic [7:0] ERR_DATA            = 8'hFF;

endpackage

// File: rtl/wait_timer.sv
// Memory-wait timer: loads MAX-1 on clear, counts down while enabled,
// expire is asserted on the last permitted waiting cycle.
module wait_timer #(
    parameter int MAX = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW   = $clog2(MAX + 1);
    localparam logic [CW-1:0] LOAD = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/cache_fill_ctrl.sv
// CPU access sequencer for the lookup cache: hits served from the cache,
// misses fetched from memory and inserted, writes go through to memory.
module cache_fill_ctrl
    import bf8b_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = MEM_TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_ready_o,
    output logic                  cpu_err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] lookup_addr_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rdata_i,
    output logic                  cache_fill_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam logic [DATA_WIDTH-1:0] ERR_WORD = {DATA_WIDTH{ERR_DATA[0]}};

    fill_state_t           state_q, state_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tmr_clear;
    logic                  tmr_en;
    logic                  tmr_expire;

    wait_timer #(
        .MAX (TIMEOUT)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (tmr_clear),
        .enable_i (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    err_d   = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                tmr_clear = 1'b1;
                if (we_q) begin
                    state_d = ST_MEM_WR;
                end else if (cache_hit_i) begin
                    data_d  = cache_rdata_i;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                tmr_en = 1'b1;
                // an ack on the expiry cycle still completes normally
                if (mem_ack_i) begin
                    data_d  = (state_q == ST_MEM_WR) ? wdata_q : mem_rdata_i;
                    state_d = ST_FILL;
                end else if (tmr_expire) begin
                    err_d   = 1'b1;
                    data_d  = ERR_WORD;
                    state_d = ST_RESP;
                end
            end
            ST_FILL: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= ERR_WORD;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // The cache registers its lookup, so the address must be presented
    // combinationally in IDLE for the result to land in LOOKUP.
    assign lookup_addr_o = ((state_q == ST_IDLE) && cpu_req_i) ? cpu_addr_i : addr_q;

    assign busy_o       = (state_q != ST_IDLE);
    assign mem_req_o    = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign mem_we_o     = (state_q == ST_MEM_WR);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign cache_fill_o = (state_q == ST_FILL);
    assign fill_addr_o  = (state_q == ST_FILL) ? addr_q : '0;
    assign fill_data_o  = (state_q == ST_FILL) ? data_q : '0;
    assign cpu_ready_o  = (state_q == ST_RESP);
    assign cpu_err_o    = (state_q == ST_RESP) && err_q;
    assign cpu_rdata_o  = data_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized self-checking bench for cache_fill_ctrl with a queue-based cache
// model and a delay-programmable memory responder.
module tb_cache_fill_ctrl;

    localparam int TMO = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cpu_req_i = 1'b0;
    logic       cpu_we_i = 1'b0;
    logic [7:0] cpu_addr_i = 8'h00;
    logic [7:0] cpu_wdata_i = 8'h00;
    logic [7:0] cpu_rdata_o;
    logic       cpu_ready_o;
    logic       cpu_err_o;
    logic       busy_o;
    logic [7:0] lookup_addr_o;
    logic       cache_hit_i = 1'b0;
    logic [7:0] cache_rdata_i = 8'hFF;
    logic       cache_fill_o;
    logic [7:0] fill_addr_o;
    logic [7:0] fill_data_o;
    logic       mem_req_o;
    logic       mem_we_o;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i = 8'h00;
    logic       mem_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } entry_t;
    entry_t cache_m[$];

    cache_fill_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_wdata_i   (cpu_wdata_i),
        .cpu_rdata_o   (cpu_rdata_o),
        .cpu_ready_o   (cpu_ready_o),
        .cpu_err_o     (cpu_err_o),
        .busy_o        (busy_o),
        .lookup_addr_o (lookup_addr_o),
        .cache_hit_i   (cache_hit_i),
        .cache_rdata_i (cache_rdata_i),
        .cache_fill_o  (cache_fill_o),
        .fill_addr_o   (fill_addr_o),
        .fill_data_o   (fill_data_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ack_i     (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Newest matching entry wins; empty lookup returns all ones.
    function automatic bit model_lookup(input logic [7:0] a, output logic [7:0] v);
        bit f = 1'b0;
        v = 8'hFF;
        foreach (cache_m[i]) begin
            if (cache_m[i].a == a) begin
                f = 1'b1;
                v = cache_m[i].d;
            end
        end
        return f;
    endfunction

    // Clock edge: the cache registers the lookup address seen just before it.
    task automatic edge_after(input logic [7:0] lk);
        logic [7:0] v;
        @(posedge clk_i);
        #1;
        mem_ack_i     = 1'b0;
        cache_hit_i   = model_lookup(lk, v);
        cache_rdata_i = v;
    endtask

    // One complete access; d = mem_req cycle index carrying mem_ack (>= TMO: never).
    task automatic do_access(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                             input int d, input logic [7:0] md, input string tag);
        logic [7:0] hv, exp_rd, exp_fd, lk;
        bit   hit, exp_err;
        int   exp_ready, exp_mem, exp_fill;
        int   memcnt, fills, ready_at;
        hit = !we && model_lookup(addr, hv);
        exp_fd = we ? wd : md;
        if (hit) begin
            exp_ready = 2; exp_mem = 0; exp_fill = 0; exp_rd = hv; exp_err = 1'b0;
        end else if (d < TMO) begin
            exp_ready = d + 4; exp_mem = d + 1; exp_fill = 1; exp_rd = exp_fd; exp_err = 1'b0;
        end else begin
            exp_ready = TMO + 2; exp_mem = TMO; exp_fill = 0; exp_rd = 8'hFF; exp_err = 1'b1;
        end
        memcnt = 0; fills = 0; ready_at = -1;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        @(negedge clk_i);
        lk = lookup_addr_o;
        checks++;
        if (lk !== addr) begin
            errors++; $display("FAIL %s lookup_addr: got %h exp %h", tag, lk, addr);
        end
        edge_after(lk);
        cpu_req_i = 1'b0;
        for (int cyc = 1; cyc <= 30 && ready_at < 0; cyc++) begin
            @(negedge clk_i);
            checks++;
            if (busy_o !== 1'b1) begin
                errors++; $display("FAIL %s busy cyc %0d: got %b exp 1", tag, cyc, busy_o);
            end
            if (mem_req_o === 1'b1) begin
                checks++;
                if (mem_we_o !== we || mem_addr_o !== addr || (we && mem_wdata_o !== wd)) begin
                    errors++;
                    $display("FAIL %s mem_bus: got we=%b a=%h wd=%h exp we=%b a=%h wd=%h",
                             tag, mem_we_o, mem_addr_o, mem_wdata_o, we, addr, wd);
                end
                if (memcnt == d) begin
                    mem_ack_i = 1'b1; mem_rdata_i = md;
                end
                memcnt++;
            end
            if (cache_fill_o === 1'b1) begin
                fills++;
                checks++;
                if (fill_addr_o !== addr || fill_data_o !== exp_fd) begin
                    errors++;
                    $display("FAIL %s fill: got %h/%h exp %h/%h", tag, fill_addr_o, fill_data_o, addr, exp_fd);
                end
                cache_m.push_back('{a: addr, d: exp_fd});
            end
            if (cpu_ready_o === 1'b1) begin
                ready_at = cyc;
                checks++;
                if (cpu_rdata_o !== exp_rd || cpu_err_o !== exp_err) begin
                    errors++;
                    $display("FAIL %s resp: got rdata=%h err=%b exp rdata=%h err=%b",
                             tag, cpu_rdata_o, cpu_err_o, exp_rd, exp_err);
                end
            end else begin
                checks++;
                if (cpu_err_o !== 1'b0) begin
                    errors++; $display("FAIL %s err_without_ready: got %b exp 0", tag, cpu_err_o);
                end
            end
            lk = lookup_addr_o;
            edge_after(lk);
        end
        checks++;
        if (ready_at != exp_ready) begin
            errors++; $display("FAIL %s ready_cycle: got %0d exp %0d", tag, ready_at, exp_ready);
        end
        checks++;
        if (memcnt != exp_mem) begin
            errors++; $display("FAIL %s mem_req_cycles: got %0d exp %0d", tag, memcnt, exp_mem);
        end
        checks++;
        if (fills != exp_fill) begin
            errors++; $display("FAIL %s fill_count: got %0d exp %0d", tag, fills, exp_fill);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || cpu_ready_o !== 1'b0 || cpu_rdata_o !== exp_rd) begin
            errors++;
            $display("FAIL %s after_resp: got busy=%b ready=%b rdata=%h exp 0/0/%h",
                     tag, busy_o, cpu_ready_o, cpu_rdata_o, exp_rd);
        end
        edge_after(lookup_addr_o);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({busy_o, cpu_ready_o, cpu_err_o, cache_fill_o, mem_req_o, mem_we_o} !== 6'b0 ||
            lookup_addr_o !== 8'h00 || fill_addr_o !== 8'h00 || fill_data_o !== 8'h00 ||
            mem_addr_o !== 8'h00 || mem_wdata_o !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got busy=%b req=%b look=%h exp all zero",
                               busy_o, mem_req_o, lookup_addr_o);
        end
        checks++;
        if (cpu_rdata_o !== 8'hFF) begin
            errors++; $display("FAIL reset_rdata: got %h exp ff", cpu_rdata_o);
        end
        rst_ni = 1'b1;
        edge_after(lookup_addr_o);
    endtask

    task automatic test_read_hit();
        cache_m.push_back('{a: 8'h10, d: 8'hA5});
        do_access(1'b0, 8'h10, 8'h00, 0, 8'h00, "read_hit");
    endtask

    task automatic test_read_miss();
        do_access(1'b0, 8'h22, 8'h00, 3, 8'h5C, "read_miss");
        do_access(1'b0, 8'h22, 8'h00, 0, 8'h00, "reread_hit");
    endtask

    task automatic test_write();
        do_access(1'b1, 8'h30, 8'h7E, 2, 8'h00, "write");
        do_access(1'b0, 8'h30, 8'h00, 0, 8'h00, "read_after_write");
        do_access(1'b1, 8'h10, 8'h3B, 0, 8'h00, "overwrite");
        do_access(1'b0, 8'h10, 8'h00, 0, 8'h00, "read_newest");
    endtask

    task automatic test_timeout();
        do_access(1'b0, 8'h44, 8'h00, 1000, 8'h00, "timeout_rd");
        do_access(1'b1, 8'h45, 8'h12, 1000, 8'h00, "timeout_wr");
    endtask

    task automatic test_ack_on_timeout();
        do_access(1'b0, 8'h55, 8'h00, TMO - 1, 8'h99, "ack_at_limit");
    endtask

    task automatic test_spurious_ack();
        mem_ack_i = 1'b1; mem_rdata_i = 8'h66;
        @(negedge clk_i);
        edge_after(lookup_addr_o);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || cpu_ready_o !== 1'b0 || mem_req_o !== 1'b0 || cache_fill_o !== 1'b0) begin
            errors++; $display("FAIL spurious_ack: got busy=%b ready=%b exp 0/0", busy_o, cpu_ready_o);
        end
        edge_after(lookup_addr_o);
    endtask

    task automatic test_back_to_back();
        logic [7:0] lk, v;
        bit   have;
        int   first, second, readies;
        have = model_lookup(8'h22, v);
        first = -1; second = -1; readies = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h22;
        @(negedge clk_i);
        edge_after(lookup_addr_o);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (cpu_ready_o === 1'b1) begin
                readies++;
                if (first < 0) first = c; else second = c;
                checks++;
                if (!have || cpu_rdata_o !== v) begin
                    errors++; $display("FAIL b2b_rdata: got %h exp %h", cpu_rdata_o, v);
                end
            end
            if (c == 3) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle_gap: got busy=%b exp 0", busy_o);
                end
            end
            if (second > 0) cpu_req_i = 1'b0;
            lk = lookup_addr_o;
            edge_after(lk);
        end
        checks++;
        if (first != 2 || second != 5 || readies != 2) begin
            errors++; $display("FAIL b2b_timing: got %0d,%0d n=%0d exp 2,5 n=2", first, second, readies);
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        seen = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h77;
        @(negedge clk_i);
        edge_after(lookup_addr_o);
        cpu_req_i = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) seen = 1'b1;
            else edge_after(lookup_addr_o);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_mid mem_req_rise: got 0 exp 1");
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || cpu_ready_o !== 1'b0 || cache_fill_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid async: got req=%b busy=%b exp 0/0", mem_req_o, busy_o);
        end
        checks++;
        if (cpu_rdata_o !== 8'hFF) begin
            errors++; $display("FAIL rst_mid rdata: got %h exp ff", cpu_rdata_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        edge_after(lookup_addr_o);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid release: got busy=%b req=%b exp 0/0", busy_o, mem_req_o);
        end
        edge_after(lookup_addr_o);
        do_access(1'b0, 8'h77, 8'h00, 1, 8'h3C, "post_reset_read");
    endtask

    task automatic test_random();
        logic       we;
        logic [7:0] addr;
        for (int i = 0; i < 40; i++) begin
            we   = ($urandom_range(0, 2) == 0);
            addr = 8'h40 + 8'($urandom_range(0, 7));
            do_access(we, addr, 8'($urandom), $urandom_range(0, TMO + 1), 8'($urandom), "random");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write();
        test_timeout();
        test_ack_on_timeout();
        test_spurious_ack();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
